gate_accum_sequencer: RTL and testbench

//  Sequences one shared S7.12 gate accumulator through an LSTM cell's gate dot-products.

---
 rtl/gate_accum_sequencer.sv | 158 +++++++++++++++
 tb/tb_gate_accum_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_accum_sequencer.sv
// gate_accum_sequencer
// Steps one shared S7.12 accumulator through the four LSTM gate dot-products
// (i, f, g, o). For each gate it clears the accumulator, counts num_terms
// accepted MAC beats, asks for the rounded S7.8 capture, then presents the
// result to the activation unit and waits for it to be taken.
module gate_accum_sequencer #(
    parameter int CNT_W     = 8,
    parameter int NUM_GATES = 4,
    localparam int GATE_W   = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    output logic              busy,
    input  logic              mac_valid,
    output logic              mac_ready,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              acc_out_en,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [GATE_W-1:0] gate_id,
    output logic              done,
    output logic              err_len
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
    localparam logic [GATE_W-1:0] GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(NUM_GATES - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  num_terms_r;
    logic [CNT_W-1:0]  term_cnt_r;
    logic [GATE_W-1:0] gate_id_r;
    logic              err_len_r;

    logic              start_ok_s;
    logic              start_bad_s;
    logic              beat_s;
    logic              last_beat_s;
    logic              accept_s;
    logic              last_gate_s;

    // Decode job requests, accepted MAC beats and result handshakes
    always_comb begin
        start_ok_s  = (state_r == ST_IDLE) && start && (num_terms != CNT_ZERO);
        start_bad_s = (state_r == ST_IDLE) && start && (num_terms == CNT_ZERO);
        beat_s      = (state_r == ST_ACCUM) && mac_valid;
        // term_cnt_r stays below num_terms_r in ACCUM, so the +1 cannot wrap
        last_beat_s = beat_s && ((term_cnt_r + CNT_ONE) == num_terms_r);
        accept_s    = (state_r == ST_RESULT) && res_ready;
        last_gate_s = (gate_id_r == GATE_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (last_beat_s) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_RESULT;
            end
            ST_RESULT: begin
                if (accept_s && !last_gate_s) begin
                    state_nxt_s = ST_CLEAR;
                end else if (accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Job length, beat counter, gate index and length-error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_terms_r <= CNT_ZERO;
            term_cnt_r  <= CNT_ZERO;
            gate_id_r   <= GATE_ZERO;
            err_len_r   <= 1'b0;
        end else begin
            err_len_r <= start_bad_s;
            if (start_ok_s) begin
                num_terms_r <= num_terms;
                gate_id_r   <= GATE_ZERO;
            end else if (accept_s && !last_gate_s) begin
                gate_id_r   <= gate_id_r + GATE_ONE;
            end else if (accept_s) begin
                gate_id_r   <= GATE_ZERO;
            end else begin
                gate_id_r   <= gate_id_r;
            end
            if (state_r == ST_CLEAR) begin
                term_cnt_r <= CNT_ZERO;
            end else if (beat_s) begin
                term_cnt_r <= term_cnt_r + CNT_ONE;
            end else begin
                term_cnt_r <= term_cnt_r;
            end
        end
    end

    // Outputs decoded from the state; edge-acting strobes are masked during
    // reset so an abandoned job never clears, accumulates or captures
    always_comb begin
        busy       = (state_r != ST_IDLE);
        mac_ready  = (state_r == ST_ACCUM);
        res_valid  = (state_r == ST_RESULT);
        gate_id    = gate_id_r;
        err_len    = err_len_r;
        acc_clr    = rst_n && (state_r == ST_CLEAR);
        acc_en     = rst_n && beat_s;
        acc_out_en = rst_n && (state_r == ST_FLUSH);
        done       = rst_n && accept_s && last_gate_s;
    end

endmodule

// File: tb/tb_gate_accum_sequencer.sv
// Self-checking bench for gate_accum_sequencer: a short vector table for the
// reset / length-error / minimum-length job, then directed and randomized jobs
// checked against a transaction-level model of the gate schedule.
module tb_gate_accum_sequencer;

    localparam int NG = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] num_terms;
    logic       busy;
    logic       mac_valid;
    logic       mac_ready;
    logic       acc_clr;
    logic       acc_en;
    logic       acc_out_en;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] gate_id;
    logic       done;
    logic       err_len;

    int checks;
    int failures;

    gate_accum_sequencer #(.CNT_W(8), .NUM_GATES(NG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms),
        .busy(busy), .mac_valid(mac_valid), .mac_ready(mac_ready),
        .acc_clr(acc_clr), .acc_en(acc_en), .acc_out_en(acc_out_en),
        .res_valid(res_valid), .res_ready(res_ready), .gate_id(gate_id),
        .done(done), .err_len(err_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rn;
        logic       st;
        logic [7:0] nt;
        logic       mv;
        logic       rr;
        logic [9:0] eo;   // {busy,mac_ready,acc_clr,acc_en,acc_out_en,res_valid,gate_id[1:0],done,err_len}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rn, input logic st, input logic [7:0] nt,
                                input logic mv, input logic rr, input logic [9:0] eo);
        vec_t v;
        v.rn = rn; v.st = st; v.nt = nt; v.mv = mv; v.rr = rr; v.eo = eo;
        return v;
    endfunction

    function automatic logic [9:0] out_word();
        return {busy, mac_ready, acc_clr, acc_en, acc_out_en, res_valid, gate_id, done, err_len};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic s, input logic [7:0] n, input logic mv,
                          input logic rr, input logic rn);
        start = s; num_terms = n; mac_valid = mv; res_ready = rr; rst_n = rn;
        #1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one job; the model tracks the gate schedule with plain counters:
    // clear one cycle after start/accept, num beats, capture one cycle after
    // the last beat, result presented until taken, done on the last take.
    task automatic run_job(input int num, input int mv_mode, input int rr_mode,
                           input bit spam, output int done_cyc);
        int gate, beats, fin_cyc, rv_cnt, clr_at;
        bit acc_on, rv_on, fin;
        logic mv, rr, st;
        logic [7:0] nt;
        gate = 0; beats = 0; fin_cyc = -10; rv_cnt = 0; clr_at = 1;
        acc_on = 0; rv_on = 0; fin = 0; done_cyc = -1;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            case (mv_mode)
                0:       mv = 1'b1;
                1:       mv = (cyc % 2 == 0);
                default: mv = ($urandom_range(0, 1) != 0);
            endcase
            case (rr_mode)
                0:       rr = 1'b1;
                1:       rr = (rv_cnt >= 10);
                default: rr = ($urandom_range(0, 1) != 0);
            endcase
            st = (cyc == 0) || spam;
            nt = (cyc != 0 && spam) ? 8'($urandom_range(0, 255)) : 8'(num);
            set_in(st, nt, mv, rr, 1'b1);
            chk("busy", busy, cyc > 0);
            chk("mac_ready", mac_ready, acc_on);
            chk("acc_clr", acc_clr, cyc == clr_at);
            chk("acc_en", acc_en, acc_on && mv);
            chk("acc_out_en", acc_out_en, cyc == fin_cyc + 1);
            chk("res_valid", res_valid, rv_on);
            chk("done", done, rv_on && rr && (gate == NG - 1));
            chk("err_len", err_len, 0);
            chk("strobe_excl", (acc_clr + acc_en + acc_out_en) <= 1, 1);
            if (cyc > 0) chk("gate_id", gate_id, gate);
            // result handshake
            if (rv_on) begin
                if (rr) begin
                    rv_on = 0; rv_cnt = 0;
                    if (gate == NG - 1) begin
                        fin = 1; done_cyc = cyc;
                    end else begin
                        gate++; clr_at = cyc + 1;
                    end
                end else begin
                    rv_cnt++;
                end
            end else if (cyc == fin_cyc + 1) begin
                rv_on = 1;
            end
            // beat counting
            if (cyc == clr_at) begin
                acc_on = 1; beats = 0;
            end else if (acc_on && mv) begin
                beats++;
                if (beats == num) begin
                    acc_on = 0; fin_cyc = cyc;
                end
            end
            next_cyc();
        end
        chk("job_finished", fin, 1);
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("busy_after_done", busy, 0);
        chk("done_after_done", done, 0);
    endtask

    int dc;
    bit found;

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0;
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        next_cyc();
        next_cyc();

        // vector table: reset state, length error, num_terms=1 full job
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 10'b0000000000));
        vecs.push_back(mk(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 10'b0000000000));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 10'b0000000001));
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 10'b0000000000));
        vecs.push_back(mk(1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 10'b0000000000));
        for (int g = 0; g < NG; g++) begin
            logic [9:0] gb;
            gb = 10'(g) << 2;
            vecs.push_back(mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 10'b1010000000 | gb));
            vecs.push_back(mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 10'b1101000000 | gb));
            vecs.push_back(mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 10'b1000100000 | gb));
            vecs.push_back(mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1,
                              10'b1000010000 | gb | ((g == NG - 1) ? 10'b0000000010 : 10'b0)));
        end
        vecs.push_back(mk(1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 10'b0000000000));
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].st, vecs[i].nt, vecs[i].mv, vecs[i].rr, vecs[i].rn);
            chk($sformatf("vec[%0d]", i), out_word(), vecs[i].eo);
            next_cyc();
        end

        // num_terms=3, streaming: done 24 cycles after start
        run_job(3, 0, 0, 1'b0, dc);
        chk("done_latency_n3", dc, 24);
        next_cyc();

        // num_terms=5 with mac_valid toggling
        run_job(5, 1, 0, 1'b0, dc);
        next_cyc();

        // result held back 10 cycles per gate
        run_job(4, 0, 1, 1'b0, dc);
        next_cyc();

        // zero-length start, then maximum length
        set_in(1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("err_busy0", busy, 0);
        next_cyc();
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("err_len_pulse", err_len, 1);
        chk("err_busy1", busy, 0);
        next_cyc();
        set_in(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("err_len_clear", err_len, 0);
        next_cyc();
        run_job(255, 0, 0, 1'b0, dc);
        chk("done_latency_n255", dc, 4 * 258);
        next_cyc();

        // reset during gate 2 accumulation
        set_in(1'b1, 8'd6, 1'b1, 1'b1, 1'b1);
        next_cyc();
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            set_in(1'b0, 8'd6, 1'b1, 1'b1, 1'b1);
            if (gate_id == 2'd2 && mac_ready) found = 1;
            else next_cyc();
        end
        chk("reach_gate2_accum", found, 1);
        set_in(1'b0, 8'd6, 1'b1, 1'b1, 1'b0);
        chk("no_out_en_in_reset", acc_out_en, 0);
        next_cyc();
        set_in(1'b0, 8'd6, 1'b1, 1'b1, 1'b1);
        chk("after_reset_outputs", out_word(), 10'b0000000000);
        next_cyc();
        run_job(2, 0, 0, 1'b0, dc);
        chk("done_latency_n2", dc, 4 * 5);
        next_cyc();

        // start pulsed every cycle of a job
        run_job(2, 2, 2, 1'b1, dc);
        next_cyc();

        // randomized jobs
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(1, 20)), 2, 2, 1'b0, dc);
            next_cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
